// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline boundary of the 32I core.
//
// Registers the selected execute result together with the write-back and
// memory controls, and holds it for MEM behind a valid/ready handshake.
// An accepted taken transfer (JAL, JALR, taken branch) produces a one-cycle
// registered redirect to IF. The following SQUASH_CYC cycles, counting the
// redirect cycle, are a squash window in which inputs are accepted and
// dropped. The transfer instruction itself still goes to MEM.
//
// Optional feature macro: EX_MEM_FWD_EN adds fwd_valid/fwd_rd/fwd_data for
// the EX operand forwarding mux. Loads are never forwarded.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid / in_ready        EX-side handshake
//   in_pc, in_imm              PC and sign-extended immediate
//   in_alu0, in_shift, in_slt  execute ALU results
//   in_branch                  comparator taken flag
//   in_res_sel                 0 alu0, 1 shift, 2 slt, 3 pc+4
//   in_is_branch/jal/jalr      control-transfer class (one-hot or zero)
//   in_rd, in_reg_we, in_mem_re, in_mem_we, in_store_data
//   out_valid / out_ready      MEM-side handshake
//   out_pc, out_result, out_store_data, out_rd, out_reg_we,
//   out_mem_re, out_mem_we     registered entry
//   redirect, redirect_pc      one-cycle PC redirect to IF
//   flush_id                   squash IF/ID, equal to redirect
//   fwd_valid, fwd_rd, fwd_data  (EX_MEM_FWD_EN only)
module ex_mem_reg #(
    parameter int unsigned SQUASH_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_alu0,
    input  logic [31:0] in_shift,
    input  logic        in_slt,
    input  logic        in_branch,
    input  logic [1:0]  in_res_sel,
    input  logic        in_is_branch,
    input  logic        in_is_jal,
    input  logic        in_is_jalr,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_we,
    input  logic        in_mem_re,
    input  logic        in_mem_we,
    input  logic [31:0] in_store_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_result,
    output logic [31:0] out_store_data,
    output logic [4:0]  out_rd,
    output logic        out_reg_we,
    output logic        out_mem_re,
    output logic        out_mem_we,
`ifdef EX_MEM_FWD_EN
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data,
`endif
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush_id
);

    localparam int unsigned CntW = 3;

    typedef enum logic {
        StRun,
        StSquash
    } state_t;

    state_t          state;
    logic [CntW-1:0] cnt;

    logic        accept;
    logic        load;
    logic        taken;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic [31:0] result;

    // Squash window always accepts so wrong-path instructions drain out of ID.
    assign in_ready = (state == StSquash) | ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign load     = accept & (state == StRun);
    assign taken    = in_is_jal | in_is_jalr | (in_is_branch & in_branch);
    assign target   = in_is_jalr ? (in_alu0 & 32'hFFFF_FFFE) : (in_pc + in_imm);
    assign pc_plus4 = in_pc + 32'd4;
    assign flush_id = redirect;

    always_comb begin
        result = in_alu0;
        unique case (in_res_sel)
            2'd0:    result = in_alu0;
            2'd1:    result = in_shift;
            2'd2:    result = {31'b0, in_slt};
            2'd3:    result = pc_plus4;
            default: result = in_alu0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= StRun;
            cnt            <= '0;
            redirect       <= 1'b0;
            redirect_pc    <= '0;
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_result     <= '0;
            out_store_data <= '0;
            out_rd         <= '0;
            out_reg_we     <= 1'b0;
            out_mem_re     <= 1'b0;
            out_mem_we     <= 1'b0;
        end else begin
            redirect <= 1'b0;
            unique case (state)
                StRun: begin
                    if (load && taken) begin
                        state       <= StSquash;
                        cnt         <= CntW'(SQUASH_CYC - 1);
                        redirect    <= 1'b1;
                        redirect_pc <= target;
                    end
                end
                StSquash: begin
                    // The cycle seen with cnt == 0 is the last dropped one.
                    if (cnt == '0) begin
                        state <= StRun;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                default: state <= StRun;
            endcase

            if (load) begin
                out_valid      <= 1'b1;
                out_pc         <= in_pc;
                out_result     <= result;
                out_store_data <= in_store_data;
                out_rd         <= in_rd;
                out_reg_we     <= in_reg_we;
                out_mem_re     <= in_mem_re;
                out_mem_we     <= in_mem_we;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef EX_MEM_FWD_EN
    assign fwd_valid = out_valid & out_reg_we & (out_rd != 5'd0) & ~out_mem_re;
    assign fwd_rd    = out_rd;
    assign fwd_data  = out_result;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed vector table for the documented scenarios,
// then randomized traffic against a squash-window scoreboard model.
module tb_ex_mem_reg;

    localparam int unsigned SquashCyc = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_imm, in_alu0, in_shift, in_store_data;
    logic        in_slt, in_branch;
    logic [1:0]  in_res_sel;
    logic        in_is_branch, in_is_jal, in_is_jalr;
    logic [4:0]  in_rd;
    logic        in_reg_we, in_mem_re, in_mem_we;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_result, out_store_data;
    logic [4:0]  out_rd;
    logic        out_reg_we, out_mem_re, out_mem_we;
    logic        redirect, flush_id;
    logic [31:0] redirect_pc;
`ifdef EX_MEM_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    always #5 clk = ~clk;

    ex_mem_reg #(.SQUASH_CYC(SquashCyc)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm), .in_alu0(in_alu0), .in_shift(in_shift),
        .in_slt(in_slt), .in_branch(in_branch), .in_res_sel(in_res_sel),
        .in_is_branch(in_is_branch), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
        .in_rd(in_rd), .in_reg_we(in_reg_we), .in_mem_re(in_mem_re),
        .in_mem_we(in_mem_we), .in_store_data(in_store_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_result(out_result), .out_store_data(out_store_data),
        .out_rd(out_rd), .out_reg_we(out_reg_we), .out_mem_re(out_mem_re),
        .out_mem_we(out_mem_we),
`ifdef EX_MEM_FWD_EN
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
        .redirect(redirect), .redirect_pc(redirect_pc), .flush_id(flush_id)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: the entry MEM should see, the pending redirect, and how many
    // more cycles of input must be thrown away.
    bit          m_known = 0;
    bit          m_valid, m_we, m_re, m_mwe, m_redir;
    logic [31:0] m_pc, m_res, m_sd, m_rpc;
    logic [4:0]  m_rd;
    int          m_left;

    task automatic tick();
        bit          exp_ready;
        bit          is_taken;
        logic [31:0] res;
        @(negedge clk);
        exp_ready = (m_left > 0) || !m_valid || out_ready;
        if (m_known) begin
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("redirect", 32'(redirect), 32'(m_redir));
            chk("flush_id", 32'(flush_id), 32'(m_redir));
            chk("redirect_pc", redirect_pc, m_rpc);
            chk("out_pc", out_pc, m_pc);
            chk("out_result", out_result, m_res);
            chk("out_store_data", out_store_data, m_sd);
            chk("out_ctl", {25'b0, out_rd, out_reg_we, out_mem_re, out_mem_we},
                {25'b0, m_rd, m_we, m_re, m_mwe});
`ifdef EX_MEM_FWD_EN
            chk("fwd_valid", 32'(fwd_valid), 32'(m_valid && m_we && m_rd != 0 && !m_re));
            chk("fwd_data", fwd_data, m_res);
`endif
        end
        if (rst) begin
            m_known = 1; m_valid = 0; m_redir = 0; m_left = 0;
            m_pc = 0; m_res = 0; m_sd = 0; m_rpc = 0; m_rd = 0;
            m_we = 0; m_re = 0; m_mwe = 0;
        end else if (m_known) begin
            m_redir = 0;
            if (in_valid && exp_ready && m_left == 0) begin
                case (in_res_sel)
                    2'd0: res = in_alu0;
                    2'd1: res = in_shift;
                    2'd2: res = in_slt ? 32'd1 : 32'd0;
                    default: res = in_pc + 32'd4;
                endcase
                m_valid = 1; m_pc = in_pc; m_res = res; m_sd = in_store_data;
                m_rd = in_rd; m_we = in_reg_we; m_re = in_mem_re; m_mwe = in_mem_we;
                is_taken = in_is_jal || in_is_jalr || (in_is_branch && in_branch);
                if (is_taken) begin
                    m_redir = 1;
                    m_rpc   = in_is_jalr ? {in_alu0[31:1], 1'b0} : in_pc + in_imm;
                    m_left  = SquashCyc;
                end
            end else begin
                if (m_left > 0) m_left--;
                if (out_ready) m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst, vld, ordy;
        logic [31:0] pc, imm, alu0, shift;
        logic        slt, br;
        logic [1:0]  sel;
        int          cls;   // 0 none, 1 branch, 2 jal, 3 jalr
        logic        ev;
        logic [31:0] er;
        logic        erd;
        logic [31:0] erpc;
    } vec_t;

    function automatic vec_t mk(logic r, logic v, logic o, logic [31:0] pc, logic [31:0] imm,
                                logic [31:0] a, logic [31:0] s, logic slt, logic br,
                                logic [1:0] sel, int cls, logic ev, logic [31:0] er,
                                logic erd, logic [31:0] erpc);
        vec_t t;
        t.rst = r; t.vld = v; t.ordy = o; t.pc = pc; t.imm = imm; t.alu0 = a;
        t.shift = s; t.slt = slt; t.br = br; t.sel = sel; t.cls = cls;
        t.ev = ev; t.er = er; t.erd = erd; t.erpc = erpc;
        return t;
    endfunction

    vec_t tbl[20];

    initial begin
        //            rst v o  pc            imm           alu0      shift     slt br sel cls ev er            rd rpc
        tbl[0]  = mk(1, 1, 1, 32'h0,        32'h0,        32'h0,    32'hF00,  0, 0, 1, 0, 0, 32'h0,        0, 32'h0);
        tbl[1]  = mk(1, 1, 1, 32'h0,        32'h0,        32'h0,    32'hF00,  0, 0, 1, 0, 0, 32'h0,        0, 32'h0);
        tbl[2]  = mk(0, 1, 1, 32'h0,        32'h0,        32'h0,    32'hF00,  0, 0, 1, 0, 1, 32'hF00,      0, 32'h0);
        tbl[3]  = mk(0, 1, 1, 32'h4,        32'h0,        32'h0,    32'h0,    1, 0, 2, 0, 1, 32'h1,        0, 32'h0);
        tbl[4]  = mk(0, 1, 0, 32'h8,        32'h0,        32'h1234, 32'h0,    0, 0, 0, 0, 1, 32'h1,        0, 32'h0);
        tbl[5]  = mk(0, 1, 0, 32'h8,        32'h0,        32'h1234, 32'h0,    0, 0, 0, 0, 1, 32'h1,        0, 32'h0);
        tbl[6]  = mk(0, 1, 0, 32'h8,        32'h0,        32'h1234, 32'h0,    0, 0, 0, 0, 1, 32'h1,        0, 32'h0);
        tbl[7]  = mk(0, 1, 1, 32'h8,        32'h0,        32'h1234, 32'h0,    0, 0, 0, 0, 1, 32'h1234,     0, 32'h0);
        tbl[8]  = mk(0, 1, 1, 32'h100,      32'hFFFF_FFF0, 32'h55,  32'h0,    0, 1, 0, 1, 1, 32'h55,       1, 32'hF0);
        tbl[9]  = mk(0, 1, 1, 32'hF0,       32'h0,        32'hAAA,  32'h0,    0, 0, 0, 0, 0, 32'h55,       0, 32'hF0);
        tbl[10] = mk(0, 1, 1, 32'hF4,       32'h0,        32'hBBB,  32'h0,    0, 0, 0, 0, 0, 32'h55,       0, 32'hF0);
        tbl[11] = mk(0, 1, 1, 32'hF8,       32'h0,        32'hCCC,  32'h0,    0, 0, 0, 0, 1, 32'hCCC,      0, 32'hF0);
        tbl[12] = mk(0, 1, 1, 32'h40,       32'h0,        32'h2003, 32'h0,    0, 0, 3, 3, 1, 32'h44,       1, 32'h2002);
        tbl[13] = mk(0, 0, 1, 32'h0,        32'h0,        32'h0,    32'h0,    0, 0, 0, 0, 0, 32'h44,       0, 32'h2002);
        tbl[14] = mk(0, 0, 1, 32'h0,        32'h0,        32'h0,    32'h0,    0, 0, 0, 0, 0, 32'h44,       0, 32'h2002);
        tbl[15] = mk(0, 1, 1, 32'hFFFF_FFFC, 32'h8,       32'h0,    32'h0,    0, 0, 3, 2, 1, 32'h0,        1, 32'h4);
        tbl[16] = mk(1, 0, 1, 32'h0,        32'h0,        32'h0,    32'h0,    0, 0, 0, 0, 0, 32'h0,        0, 32'h0);
        tbl[17] = mk(0, 1, 1, 32'h10,       32'h0,        32'h77,   32'h0,    0, 0, 0, 0, 1, 32'h77,       0, 32'h0);
        tbl[18] = mk(0, 1, 1, 32'h200,      32'h10,       32'h99,   32'h0,    0, 0, 0, 1, 1, 32'h99,       0, 32'h0);
        tbl[19] = mk(0, 0, 1, 32'h0,        32'h0,        32'h0,    32'h0,    0, 0, 0, 0, 0, 32'h99,       0, 32'h0);

        in_mem_re = 0; in_mem_we = 0;
        for (int i = 0; i < 20; i++) begin
            rst = tbl[i].rst; in_valid = tbl[i].vld; out_ready = tbl[i].ordy;
            in_pc = tbl[i].pc; in_imm = tbl[i].imm; in_alu0 = tbl[i].alu0;
            in_shift = tbl[i].shift; in_slt = tbl[i].slt; in_branch = tbl[i].br;
            in_res_sel = tbl[i].sel;
            in_is_branch = (tbl[i].cls == 1); in_is_jal = (tbl[i].cls == 2);
            in_is_jalr = (tbl[i].cls == 3);
            in_rd = 5'(i); in_reg_we = 1; in_store_data = 32'hD000_0000 + 32'(i);
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_result", i), out_result, tbl[i].er);
            chk($sformatf("vec%0d_redirect", i), 32'(redirect), 32'(tbl[i].erd));
            chk($sformatf("vec%0d_rpc", i), redirect_pc, tbl[i].erpc);
        end

        for (int n = 0; n < 3000; n++) begin
            int cls;
            rst = ($urandom_range(0, 63) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_pc = $urandom; in_imm = $urandom; in_alu0 = $urandom; in_shift = $urandom;
            in_slt = 1'($urandom); in_branch = 1'($urandom); in_res_sel = 2'($urandom);
            cls = $urandom_range(0, 5);
            in_is_branch = (cls == 3); in_is_jal = (cls == 4); in_is_jalr = (cls == 5);
            in_rd = 5'($urandom); in_reg_we = 1'($urandom); in_mem_re = 1'($urandom);
            in_mem_we = 1'($urandom); in_store_data = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
